// File: rtl/wb_grf_pkg.sv
// wb_grf_pkg: shared widths for the write-back register file.
package wb_grf_pkg;
    localparam int GRF_DATA_W = 32;
    localparam int GRF_ADDR_W = 5;
    localparam int GRF_CNT_W  = 32;
    localparam int GRF_PC_W   = 32;
endpackage

// File: rtl/wb_grf_read_port.sv
// wb_grf_read_port: one combinational GRF read port with $0 forcing.
// GRF_BYPASS_EN adds same-cycle write-through from the committing WB write.
module wb_grf_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] word,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    output logic [DATA_W-1:0] data
);
`ifdef GRF_BYPASS_EN
    assign data = (addr == '0) ? '0 : (commit && addr == wr_addr) ? wr_data : word;
`else
    logic unused_bypass;
    assign unused_bypass = ^{commit, wr_addr, wr_data};
    assign data = (addr == '0) ? '0 : word;
`endif
endmodule

// File: rtl/wb_grf.sv
// wb_grf: write-back register file with two read ports, write trace and saturating commit counter.
// Define GRF_BYPASS_EN for same-cycle write-through on the read ports.
module wb_grf
    import wb_grf_pkg::*;
#(
    parameter int DATA_W = GRF_DATA_W,
    parameter int ADDR_W = GRF_ADDR_W,
    parameter int CNT_W  = GRF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RegWriteWB,
    input  logic [ADDR_W-1:0]   RegAddrWB,
    input  logic [DATA_W-1:0]   RegDataWB,
    input  logic [GRF_PC_W-1:0] pcWB,
    input  logic [ADDR_W-1:0]   A1,
    input  logic [ADDR_W-1:0]   A2,
    output logic [DATA_W-1:0]   RD1,
    output logic [DATA_W-1:0]   RD2,
    output logic                traceValid,
    output logic [GRF_PC_W-1:0] tracePC,
    output logic [ADDR_W-1:0]   traceAddr,
    output logic [DATA_W-1:0]   traceData,
    output logic [CNT_W-1:0]    wbCount
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              commit;

    // Writes to $0 are dropped here so neither storage, trace nor counter see them.
    assign commit = !reset && RegWriteWB && (RegAddrWB != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            traceValid <= 1'b0;
            tracePC    <= '0;
            traceAddr  <= '0;
            traceData  <= '0;
            wbCount    <= '0;
        end else begin
            traceValid <= commit;
            if (commit) begin
                regs[RegAddrWB] <= RegDataWB;
                tracePC         <= pcWB;
                traceAddr       <= RegAddrWB;
                traceData       <= RegDataWB;
                if (wbCount != '1) wbCount <= wbCount + 1'b1;
            end
        end
    end

    wb_grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (
        .addr(A1), .word(regs[A1]), .wr_addr(RegAddrWB), .wr_data(RegDataWB),
        .commit(commit), .data(RD1)
    );

    wb_grf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (
        .addr(A2), .word(regs[A2]), .wr_addr(RegAddrWB), .wr_data(RegDataWB),
        .commit(commit), .data(RD2)
    );
endmodule

// File: tb/tb_wb_grf.sv
// tb_wb_grf: directed checks of wb_grf; a second instance with a 4-bit counter covers saturation.
module tb_wb_grf;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RegWriteWB = 1'b0;
    logic [4:0]  RegAddrWB = '0;
    logic [31:0] RegDataWB = '0;
    logic [31:0] pcWB = '0;
    logic [4:0]  A1 = '0;
    logic [4:0]  A2 = '0;
    logic [31:0] RD1, RD2, tracePC, traceData, wbCount;
    logic        traceValid;
    logic [4:0]  traceAddr;
    logic [31:0] s_RD1, s_RD2, s_tracePC, s_traceData;
    logic        s_traceValid;
    logic [4:0]  s_traceAddr;
    logic [3:0]  s_wbCount;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_grf dut (
        .clk(clk), .reset(reset), .RegWriteWB(RegWriteWB), .RegAddrWB(RegAddrWB),
        .RegDataWB(RegDataWB), .pcWB(pcWB), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .traceValid(traceValid), .tracePC(tracePC), .traceAddr(traceAddr),
        .traceData(traceData), .wbCount(wbCount)
    );

    wb_grf #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .RegWriteWB(RegWriteWB), .RegAddrWB(RegAddrWB),
        .RegDataWB(RegDataWB), .pcWB(pcWB), .A1(A1), .A2(A2), .RD1(s_RD1), .RD2(s_RD2),
        .traceValid(s_traceValid), .tracePC(s_tracePC), .traceAddr(s_traceAddr),
        .traceData(s_traceData), .wbCount(s_wbCount)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        RegWriteWB = 1'b1; RegAddrWB = a; RegDataWB = d; pcWB = pc;
        step();
        RegWriteWB = 1'b0;
    endtask

    task automatic test_reset();
        wr(5'd5, 32'h0000_0055, 32'h100);
        reset = 1'b1; RegWriteWB = 1'b1; RegAddrWB = 5'd5; RegDataWB = 32'h77; pcWB = 32'h200;
        step();
        reset = 1'b0; RegWriteWB = 1'b0; A1 = 5'd5; A2 = 5'd5;
        #1;
        checks++; if (RD1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h exp %h", RD1, 32'h0); end
        checks++; if (RD2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got %h exp %h", RD2, 32'h0); end
        checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL reset_tv got %b exp 0", traceValid); end
        checks++; if (tracePC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", tracePC); end
        checks++; if (wbCount !== 32'h0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", wbCount); end
        step();
        checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL reset_tv2 got %b exp 0", traceValid); end
    endtask

    task automatic test_write();
        wr(5'd3, 32'h1234_5678, 32'h3000);
        A1 = 5'd3;
        #1;
        checks++; if (RD1 !== 32'h1234_5678) begin errors++; $display("FAIL wr_rd1 got %h exp %h", RD1, 32'h1234_5678); end
        checks++; if (traceValid !== 1'b1) begin errors++; $display("FAIL wr_tv got %b exp 1", traceValid); end
        checks++; if (tracePC !== 32'h3000) begin errors++; $display("FAIL wr_pc got %h exp %h", tracePC, 32'h3000); end
        checks++; if (traceAddr !== 5'd3) begin errors++; $display("FAIL wr_addr got %0d exp 3", traceAddr); end
        checks++; if (traceData !== 32'h1234_5678) begin errors++; $display("FAIL wr_data got %h exp %h", traceData, 32'h1234_5678); end
        checks++; if (wbCount !== 32'd1) begin errors++; $display("FAIL wr_cnt got %0d exp 1", wbCount); end
        step();
        checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL wr_tv_drop got %b exp 0", traceValid); end
    endtask

    task automatic test_zero_reg();
        wr(5'd0, 32'hFFFF_FFFF, 32'h3004);
        A1 = 5'd0;
        #1;
        checks++; if (RD1 !== 32'h0) begin errors++; $display("FAIL z_rd1 got %h exp 0", RD1); end
        checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL z_tv got %b exp 0", traceValid); end
        checks++; if (wbCount !== 32'd1) begin errors++; $display("FAIL z_cnt got %0d exp 1", wbCount); end
        checks++; if (tracePC !== 32'h3000) begin errors++; $display("FAIL z_pc_hold got %h exp %h", tracePC, 32'h3000); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
`ifdef GRF_BYPASS_EN
        exp_same = 32'hA5A5_A5A5;
`else
        exp_same = 32'h1;
`endif
        wr(5'd7, 32'h1, 32'h3008);
        RegWriteWB = 1'b1; RegAddrWB = 5'd7; RegDataWB = 32'hA5A5_A5A5; pcWB = 32'h300C;
        A1 = 5'd7; A2 = 5'd7;
        #1;
        checks++; if (RD1 !== exp_same) begin errors++; $display("FAIL byp_rd1 got %h exp %h", RD1, exp_same); end
        checks++; if (RD2 !== exp_same) begin errors++; $display("FAIL byp_rd2 got %h exp %h", RD2, exp_same); end
        step();
        RegWriteWB = 1'b0;
        #1;
        checks++; if (RD1 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp_rd1_next got %h exp %h", RD1, 32'hA5A5_A5A5); end
        checks++; if (RD2 !== 32'hA5A5_A5A5) begin errors++; $display("FAIL byp_rd2_next got %h exp %h", RD2, 32'hA5A5_A5A5); end
        checks++; if (wbCount !== 32'd3) begin errors++; $display("FAIL byp_cnt got %0d exp 3", wbCount); end
        RegWriteWB = 1'b1; RegAddrWB = 5'd0; RegDataWB = 32'hDEAD_BEEF; A1 = 5'd0;
        #1;
        checks++; if (RD1 !== 32'h0) begin errors++; $display("FAIL byp_zero got %h exp 0", RD1); end
        RegWriteWB = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        A1 = 5'd9;
        for (int k = 1; k <= 3; k++) begin
            RegWriteWB = 1'b1; RegAddrWB = 5'd9; RegDataWB = 32'(k); pcWB = 32'h4000 + 32'(4 * k);
            step();
            checks++; if (traceValid !== 1'b1) begin errors++; $display("FAIL b2b_tv%0d got %b exp 1", k, traceValid); end
            checks++; if (traceData !== 32'(k)) begin errors++; $display("FAIL b2b_data%0d got %0d exp %0d", k, traceData, k); end
            checks++; if (traceAddr !== 5'd9) begin errors++; $display("FAIL b2b_addr%0d got %0d exp 9", k, traceAddr); end
        end
        RegWriteWB = 1'b0;
        #1;
        checks++; if (RD1 !== 32'd3) begin errors++; $display("FAIL b2b_rd got %0d exp 3", RD1); end
        checks++; if (tracePC !== 32'h400C) begin errors++; $display("FAIL b2b_pc got %h exp %h", tracePC, 32'h400C); end
        checks++; if (wbCount !== 32'd6) begin errors++; $display("FAIL b2b_cnt got %0d exp 6", wbCount); end
        step();
        checks++; if (traceValid !== 1'b0) begin errors++; $display("FAIL b2b_tv_end got %b exp 0", traceValid); end
    endtask

    task automatic test_saturate();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 14; k++) wr(5'd1, 32'(k), 32'h5000);
        checks++; if (s_wbCount !== 4'hE) begin errors++; $display("FAIL sat_cnt14 got %h exp %h", s_wbCount, 4'hE); end
        wr(5'd1, 32'd15, 32'h5000);
        checks++; if (s_wbCount !== 4'hF) begin errors++; $display("FAIL sat_cnt15 got %h exp %h", s_wbCount, 4'hF); end
        wr(5'd1, 32'd16, 32'h5000);
        checks++; if (s_wbCount !== 4'hF) begin errors++; $display("FAIL sat_hold got %h exp %h", s_wbCount, 4'hF); end
        checks++; if (wbCount !== 32'd16) begin errors++; $display("FAIL sat_wide got %0d exp 16", wbCount); end
        checks++; if (s_traceData !== 32'd16) begin errors++; $display("FAIL sat_trace got %0d exp 16", s_traceData); end
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_write();
        test_zero_reg();
        test_bypass();
        test_back_to_back();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
